// File: rtl/conv_res_packer.sv
// conv_res_packer
//
// Packs signed 24-bit convolution results into 8-bit activations (optional
// ReLU, arithmetic right shift, saturation), assembles four bytes per 32-bit
// word (first byte in bits [7:0]) and buffers the words in a
// first-word-fall-through FIFO for the host.
//
// Handshake: a byte is accepted on every rising edge where in_valid=1.
// A word is popped on every rising edge where rd_en=1 and rd_valid=1;
// rd_en while rd_valid=0 is ignored. Push and pop may coincide, even when the
// FIFO is full.
//
// Ports
//   clk       single clock, all state changes on its rising edge
//   rst_ni    synchronous active-low reset (same effect as clear, higher priority)
//   in_valid  one conv result is present this cycle
//   in_data   signed 24-bit conv result
//   relu_en   1: ReLU + unsigned 8-bit clamp, 0: signed 8-bit clamp
//   shift     arithmetic right shift applied before saturation (capped at 23)
//   flush     push the partially filled word (no-op when nothing is pending)
//   clear     synchronous flush-and-discard of all state
//   rd_en     host pop request
//   rd_data   oldest FIFO word, 0 while empty
//   rd_valid  FIFO non-empty
//   full      FIFO holds DEPTH words
//   count     number of words held
//   overflow  sticky: a completed word was dropped because the FIFO was full

module conv_res_packer #(
    parameter int DEPTH = 8,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst_ni,
    input  logic          in_valid,
    input  logic [23:0]   in_data,
    input  logic          relu_en,
    input  logic [4:0]    shift,
    input  logic          flush,
    input  logic          clear,
    input  logic          rd_en,
    output logic [31:0]   rd_data,
    output logic          rd_valid,
    output logic          full,
    output logic [CW-1:0] count,
    output logic          overflow
);

    localparam int AW = $clog2(DEPTH);

    // ------------------------------------------------------------------
    // Byte path
    // ------------------------------------------------------------------
    logic [4:0]         sh_amt;
    logic signed [23:0] relu_val;
    logic signed [23:0] shifted;
    logic [7:0]         byte_val;

    always_comb begin
        // Shifting a 24-bit value by more than 23 only replicates the sign,
        // so capping at 23 gives the same result with a narrower shifter.
        sh_amt   = (shift > 5'd23) ? 5'd23 : shift;
        relu_val = (relu_en && in_data[23]) ? 24'sd0 : $signed(in_data);
        shifted  = relu_val >>> sh_amt;
    end

    always_comb begin
        byte_val = shifted[7:0];
        if (relu_en) begin
            // ReLU already removed negatives; only the upper bound matters.
            if (shifted > 24'sd255) begin
                byte_val = 8'hFF;
            end
        end else begin
            if (shifted > 24'sd127) begin
                byte_val = 8'h7F;
            end else if (shifted < -24'sd128) begin
                byte_val = 8'h80;
            end
        end
    end

    // ------------------------------------------------------------------
    // Word assembly
    // ------------------------------------------------------------------
    logic [1:0]  lane;
    logic [31:0] asm_word;
    logic [1:0]  lane_after;
    logic [31:0] merged;
    logic        word_done;
    logic        push_req;

    always_comb begin
        merged = asm_word;
        if (in_valid) begin
            case (lane)
                2'd0:    merged[7:0]   = byte_val;
                2'd1:    merged[15:8]  = byte_val;
                2'd2:    merged[23:16] = byte_val;
                default: merged[31:24] = byte_val;
            endcase
        end
    end

    // The incoming byte is inserted before flush is considered, so a flush
    // that coincides with the fourth byte pushes exactly one word, and a flush
    // with nothing pending pushes nothing.
    assign lane_after = lane + {1'b0, in_valid};
    assign word_done  = in_valid && (lane == 2'd3);
    assign push_req   = word_done || (flush && (lane_after != 2'd0));

    // ------------------------------------------------------------------
    // FIFO
    // ------------------------------------------------------------------
    logic [31:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          pop;
    logic          push_ok;
    logic          drop;

    assign rd_valid = (count != '0);
    assign full     = (count == CW'(DEPTH));
    assign rd_data  = rd_valid ? mem[rd_ptr] : 32'd0;

    assign pop     = rd_en && rd_valid;
    // A pop on the same edge frees the head slot, so a push into a full FIFO
    // still succeeds; when full, wr_ptr equals rd_ptr and the new word lands
    // in the slot being vacated, becoming the tail.
    assign push_ok = push_req && (!full || pop);
    assign drop    = push_req && full && !pop;

    // Storage is deliberately left out of reset; rd_data is masked while empty.
    always_ff @(posedge clk) begin
        if (rst_ni && !clear && push_ok) begin
            mem[wr_ptr] <= merged;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_ni || clear) begin
            lane     <= 2'd0;
            asm_word <= 32'd0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            // Assembly register: a push (accepted or dropped) always restarts
            // the next word at lane 0.
            if (push_req) begin
                lane     <= 2'd0;
                asm_word <= 32'd0;
            end else if (in_valid) begin
                lane     <= lane_after;
                asm_word <= merged;
            end

            if (push_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end

            case ({push_ok, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase

            if (drop) begin
                overflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_conv_res_packer.sv
module tb_conv_res_packer;

  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_ni;
  logic          in_valid;
  logic [23:0]   in_data;
  logic          relu_en;
  logic [4:0]    shift;
  logic          flush;
  logic          clear;
  logic          rd_en;
  logic [31:0]   rd_data;
  logic          rd_valid;
  logic          full;
  logic [CW-1:0] count;
  logic          overflow;

  conv_res_packer #(.DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst_ni   (rst_ni),
    .in_valid (in_valid),
    .in_data  (in_data),
    .relu_en  (relu_en),
    .shift    (shift),
    .flush    (flush),
    .clear    (clear),
    .rd_en    (rd_en),
    .rd_data  (rd_data),
    .rd_valid (rd_valid),
    .full     (full),
    .count    (count),
    .overflow (overflow)
  );

  // ---------------- reference model ----------------
  logic [31:0] exp_q[$];   // words held by the FIFO, oldest first
  logic [7:0]  byte_q[$];  // bytes of the word under assembly
  logic        m_ovf;

  int checks = 0;
  int errors = 0;

  function automatic logic [7:0] ref_byte(input logic [23:0] d, input logic re,
                                          input logic [4:0] sh);
    int v;
    int s;
    v = $signed(d);
    if (re && v < 0) v = 0;
    s = (sh > 5'd23) ? 23 : int'(sh);
    v = v >>> s;
    if (re) begin
      if (v > 255) v = 255;
    end else begin
      if (v > 127) v = 127;
      if (v < -128) v = -128;
    end
    return v[7:0];
  endfunction

  task automatic model_edge(input logic iv, input logic [23:0] d, input logic re,
                            input logic [4:0] sh, input logic fl, input logic cl,
                            input logic rd);
    logic [31:0] w;
    logic        do_push;
    logic        do_pop;
    if (!rst_ni || cl) begin
      exp_q.delete();
      byte_q.delete();
      m_ovf = 1'b0;
      return;
    end
    do_pop  = rd && (exp_q.size() > 0);
    do_push = 1'b0;
    w       = 32'd0;
    if (iv) byte_q.push_back(ref_byte(d, re, sh));
    if (byte_q.size() == 4 || (fl && byte_q.size() != 0)) begin
      foreach (byte_q[i]) w = w | (32'(byte_q[i]) << (8 * i));
      byte_q.delete();
      do_push = 1'b1;
    end
    if (do_pop) void'(exp_q.pop_front());
    if (do_push) begin
      if (exp_q.size() < DEPTH) exp_q.push_back(w);
      else m_ovf = 1'b1;
    end
  endtask

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    logic [31:0] exp_head;
    exp_head = (exp_q.size() > 0) ? exp_q[0] : 32'd0;
    check({tag, ".count"},    32'(count),    32'(exp_q.size()));
    check({tag, ".rd_valid"}, 32'(rd_valid), 32'(exp_q.size() != 0));
    check({tag, ".full"},     32'(full),     32'(exp_q.size() == DEPTH));
    check({tag, ".overflow"}, 32'(overflow), 32'(m_ovf));
    check({tag, ".rd_data"},  rd_data,       exp_head);
  endtask

  // ---------------- driver tasks ----------------
  task automatic step(input string tag, input logic iv, input logic [23:0] d,
                      input logic re, input logic [4:0] sh, input logic fl,
                      input logic cl, input logic rd);
    in_valid = iv;
    in_data  = d;
    relu_en  = re;
    shift    = sh;
    flush    = fl;
    clear    = cl;
    rd_en    = rd;
    @(posedge clk);
    model_edge(iv, d, re, sh, fl, cl, rd);
    #1;
    check_all(tag);
    in_valid = 1'b0;
    flush    = 1'b0;
    clear    = 1'b0;
    rd_en    = 1'b0;
  endtask

  task automatic idle(input string tag);
    step(tag, 1'b0, 24'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic push_byte(input string tag, input logic [23:0] d, input logic re,
                           input logic [4:0] sh);
    step(tag, 1'b1, d, re, sh, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic pop_word(input string tag);
    step(tag, 1'b0, 24'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic do_clear(input string tag);
    step(tag, 1'b0, 24'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic do_reset(input string tag);
    rst_ni = 1'b0;
    idle(tag);
    rst_ni = 1'b1;
  endtask

  task automatic push_rand_word(input string tag);
    for (int i = 0; i < 4; i++)
      push_byte(tag, 24'($urandom), 1'($urandom_range(0, 1)), 5'($urandom_range(0, 12)));
  endtask

  function automatic logic [23:0] rand_data();
    case ($urandom_range(0, 4))
      0: return 24'h7FFFFF;
      1: return 24'h800000;
      2: return 24'($urandom_range(0, 400));
      3: return 24'(-$urandom_range(0, 400));
      default: return 24'($urandom);
    endcase
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    rst_ni   = 1'b0;
    in_valid = 1'b0;
    in_data  = 24'd0;
    relu_en  = 1'b0;
    shift    = 5'd0;
    flush    = 1'b0;
    clear    = 1'b0;
    rd_en    = 1'b0;
    exp_q.delete();
    byte_q.delete();
    m_ovf = 1'b0;

    // reset state
    idle("reset0");
    idle("reset1");
    rst_ni = 1'b1;
    idle("post_reset");

    // ReLU, no shift
    push_byte("relu_b0", 24'd10, 1'b1, 5'd0);
    push_byte("relu_b1", -24'sd5, 1'b1, 5'd0);
    push_byte("relu_b2", 24'd300, 1'b1, 5'd0);
    push_byte("relu_b3", 24'd255, 1'b1, 5'd0);
    check("relu_word", rd_data, 32'hFFFF000A);
    check("relu_count", 32'(count), 32'd1);
    pop_word("relu_pop");

    // signed with shift 4
    push_byte("sgn_b0", 24'd256, 1'b0, 5'd4);
    push_byte("sgn_b1", -24'sd32, 1'b0, 5'd4);
    push_byte("sgn_b2", 24'h7FFFFF, 1'b0, 5'd4);
    push_byte("sgn_b3", 24'h800000, 1'b0, 5'd4);
    check("sgn_word", rd_data, 32'h807FFE10);
    pop_word("sgn_pop");

    // partial flush, then a flush with nothing pending
    push_byte("fl_b0", 24'd1, 1'b1, 5'd0);
    push_byte("fl_b1", 24'd2, 1'b1, 5'd0);
    step("fl_push", 1'b0, 24'd0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0);
    check("fl_word", rd_data, 32'h00000201);
    step("fl_empty", 1'b0, 24'd0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0);
    check("fl_empty_count", 32'(count), 32'd1);
    // flush together with the fourth byte pushes one word
    do_clear("clr_a");
    for (int i = 0; i < 3; i++) push_byte("fl4_b", 24'(i + 1), 1'b0, 5'd0);
    step("fl4_last", 1'b1, 24'd4, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0);
    check("fl4_count", 32'(count), 32'd1);
    check("fl4_word", rd_data, 32'h04030201);

    // overflow: five words into a depth-4 FIFO
    do_clear("clr_b");
    for (int i = 0; i < 5; i++) push_rand_word("ovf_push");
    check("ovf_count", 32'(count), 32'(DEPTH));
    check("ovf_flag", 32'(overflow), 32'd1);
    for (int i = 0; i < 4; i++) pop_word("ovf_pop");
    pop_word("empty_pop");
    idle("empty_idle");

    // full FIFO, fourth byte and pop on the same edge
    do_clear("clr_c");
    for (int i = 0; i < DEPTH; i++) push_rand_word("full_push");
    for (int i = 0; i < 3; i++) push_byte("full_b", 24'(8 * i + 7), 1'b1, 5'd0);
    step("full_pushpop", 1'b1, 24'd99, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1);
    check("full_pp_count", 32'(count), 32'(DEPTH));
    check("full_pp_ovf", 32'(overflow), 32'd0);
    for (int i = 0; i < DEPTH; i++) pop_word("full_drain");

    // reset mid-word with two words buffered
    do_clear("clr_d");
    push_rand_word("rst_w0");
    push_rand_word("rst_w1");
    for (int i = 0; i < 3; i++) push_byte("rst_partial", 24'($urandom), 1'b0, 5'd0);
    do_reset("rst_mid");
    check("rst_count", 32'(count), 32'd0);
    push_byte("rst_b0", 24'd17, 1'b0, 5'd0);
    push_byte("rst_b1", 24'd18, 1'b0, 5'd0);
    push_byte("rst_b2", 24'd19, 1'b0, 5'd0);
    push_byte("rst_b3", 24'd20, 1'b0, 5'd0);
    check("rst_word", rd_data, 32'h14131211);

    // clear wins over simultaneous inputs
    step("clr_prio", 1'b1, 24'd5, 1'b0, 5'd0, 1'b1, 1'b1, 1'b1);
    idle("clr_after");

    // randomized traffic
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 79) == 0) begin
        do_reset("rnd_reset");
      end else begin
        step("rnd",
             1'($urandom_range(0, 2) != 0),
             rand_data(),
             1'($urandom_range(0, 1)),
             5'($urandom_range(0, 31)),
             1'($urandom_range(0, 5) == 0),
             1'($urandom_range(0, 49) == 0),
             1'($urandom_range(0, 2) == 0));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
